// File: rtl/y86_pkg.sv
// Shared Y86-64 decode constants: icodes, jXX/cmovXX condition ifuns and CC flag bit positions.
package y86_pkg;

  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;

endpackage

// File: rtl/cc_unit_cond_eval.sv
// Combinational jXX/cmovXX condition decode from a {OF,SF,ZF} flag triple.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  input  logic [3:0] icode,
  output logic       cnd,
  output logic       illegal
);

  logic lt;

  assign lt = cc[CC_SF] ^ cc[CC_OF];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | cc[CC_ZF];
      C_L:     cnd = lt;
      C_E:     cnd = cc[CC_ZF];
      C_NE:    cnd = ~cc[CC_ZF];
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~cc[CC_ZF];
      default: cnd = 1'b0;
    endcase
  end

  // Out-of-range ifun only matters for the two condition-consuming icodes.
  assign illegal = (ifun > C_G) && ((icode == I_JXX) || (icode == I_CMOVXX));

endmodule

// File: rtl/cc_unit.sv
// Y86-64 condition-code register, Execute condition evaluation and M-stage condition register.
// Optional CC write counter enabled by defining CC_TRACE_EN.
module cc_unit
  import y86_pkg::*;
#(
  parameter logic [2:0] CC_RESET = 3'b001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_ifun,
  input  logic [2:0]  alu_cf,
  input  logic        set_cc,
  input  logic        m_exc,
  input  logic        w_exc,
  input  logic        m_stall,
  input  logic        m_bubble,
  output logic [2:0]  cc_q,
  output logic        e_cnd,
  output logic        e_cnd_illegal,
  output logic        M_cnd
`ifdef CC_TRACE_EN
  ,
  output logic [15:0] cc_update_cnt
`endif
);

  logic cc_we;

  // A faulting older instruction or a held M stage must not let this OPq commit flags.
  assign cc_we = set_cc & ~m_exc & ~w_exc & ~m_stall;

  cond_eval u_cond_eval (
    .cc      (cc_q),
    .ifun    (e_ifun),
    .icode   (e_icode),
    .cnd     (e_cnd),
    .illegal (e_cnd_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= CC_RESET;
    end else if (cc_we) begin
      cc_q <= alu_cf;
    end
  end

  // E -> M stage boundary; stall outranks bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_cnd <= 1'b0;
    end else if (m_stall) begin
      M_cnd <= M_cnd;
    end else if (m_bubble) begin
      M_cnd <= 1'b0;
    end else begin
      M_cnd <= e_cnd;
    end
  end

`ifdef CC_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_update_cnt <= 16'd0;
    end else if (cc_we) begin
      cc_update_cnt <= cc_update_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cc_unit.sv
// Randomized self-checking bench for cc_unit against a flag-semantics reference model.
module tb_cc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  e_icode, e_ifun;
  logic [2:0]  alu_cf;
  logic        set_cc, m_exc, w_exc, m_stall, m_bubble;
  logic [2:0]  cc_q;
  logic        e_cnd, e_cnd_illegal, M_cnd;
`ifdef CC_TRACE_EN
  logic [15:0] cc_update_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [2:0]  m_cc;
  logic        m_mcnd;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  cc_unit #(.CC_RESET(3'b001)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .e_icode       (e_icode),
    .e_ifun        (e_ifun),
    .alu_cf        (alu_cf),
    .set_cc        (set_cc),
    .m_exc         (m_exc),
    .w_exc         (w_exc),
    .m_stall       (m_stall),
    .m_bubble      (m_bubble),
    .cc_q          (cc_q),
    .e_cnd         (e_cnd),
    .e_cnd_illegal (e_cnd_illegal),
    .M_cnd         (M_cnd)
`ifdef CC_TRACE_EN
    ,
    .cc_update_cnt (cc_update_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: interpret flags as the outcome of a signed comparison a-b.
  function automatic logic ref_cnd(input logic [3:0] fn, input logic [2:0] f);
    logic zero, less;
    zero = f[0];
    less = f[1] != f[2];
    case (int'(fn))
      0: return 1'b1;
      1: return less || zero;
      2: return less;
      3: return zero;
      4: return !zero;
      5: return !less;
      6: return !less && !zero;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [3:0] ic, input logic [3:0] fn);
    return (ic == 4'd7 || ic == 4'd2) && (int'(fn) > 6);
  endfunction

  task automatic model_reset();
    m_cc = 3'b001;
    m_mcnd = 1'b0;
    m_cnt = 16'd0;
  endtask

  // Called just after a falling edge: apply, check, advance model across the next rising edge.
  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] cf,
                       input logic sc, input logic me, input logic we,
                       input logic st, input logic bb);
    logic nxt;
    e_icode = ic; e_ifun = fn; alu_cf = cf;
    set_cc = sc; m_exc = me; w_exc = we; m_stall = st; m_bubble = bb;
    #1;
    chk("cc_q", {13'd0, cc_q}, {13'd0, m_cc});
    chk("e_cnd", {15'd0, e_cnd}, {15'd0, ref_cnd(fn, m_cc)});
    chk("e_cnd_illegal", {15'd0, e_cnd_illegal}, {15'd0, ref_illegal(ic, fn)});
    chk("M_cnd", {15'd0, M_cnd}, {15'd0, m_mcnd});
`ifdef CC_TRACE_EN
    chk("cc_update_cnt", cc_update_cnt, m_cnt);
`endif
    if (st) nxt = m_mcnd;
    else if (bb) nxt = 1'b0;
    else nxt = ref_cnd(fn, m_cc);
    if (sc && !me && !we && !st) begin
      m_cc = cf;
      m_cnt = m_cnt + 16'd1;
    end
    m_mcnd = nxt;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_cc_q", {13'd0, cc_q}, 16'h0001);
    chk("rst_M_cnd", {15'd0, M_cnd}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    e_icode = 4'd0; e_ifun = 4'd0; alu_cf = 3'd0;
    set_cc = 1'b0; m_exc = 1'b0; w_exc = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state and je on reset flags (ZF=1)
    e_icode = 4'd7; e_ifun = 4'd3;
    #1;
    chk("rst_cc", {13'd0, cc_q}, 16'h0001);
    chk("rst_mcnd", {15'd0, M_cnd}, 16'h0000);
    chk("rst_je", {15'd0, e_cnd}, 16'h0001);
`ifdef CC_TRACE_EN
    chk("rst_cnt", cc_update_cnt, 16'h0000);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // OPq write then back-to-back jl / jge
    drive(4'd6, 4'd0, 3'b010, 1, 0, 0, 0, 0);
    chk("opq_cc", {13'd0, cc_q}, 16'h0002);
    drive(4'd7, 4'd2, 3'b000, 0, 0, 0, 0, 0);
    chk("jl_mcnd", {15'd0, M_cnd}, 16'h0001);
    drive(4'd7, 4'd5, 3'b000, 0, 0, 0, 0, 0);
    chk("jge_mcnd", {15'd0, M_cnd}, 16'h0000);

    // Exception suppression
    do_reset();
    drive(4'd6, 4'd0, 3'b100, 1, 0, 1, 0, 0);
    chk("wexc_cc", {13'd0, cc_q}, 16'h0001);
    drive(4'd6, 4'd0, 3'b100, 1, 1, 0, 0, 0);
    chk("mexc_cc", {13'd0, cc_q}, 16'h0001);

    // Stall / bubble priority, and CC write blocked under stall
    drive(4'd7, 4'd0, 3'b000, 0, 0, 0, 0, 1);
    drive(4'd7, 4'd0, 3'b110, 1, 0, 0, 1, 0);
    chk("stall_hold", {15'd0, M_cnd}, 16'h0000);
    chk("stall_nocc", {13'd0, cc_q}, 16'h0001);
    drive(4'd7, 4'd0, 3'b000, 0, 0, 0, 0, 0);
    chk("load_cnd", {15'd0, M_cnd}, 16'h0001);
    drive(4'd7, 4'd0, 3'b000, 0, 0, 0, 1, 1);
    chk("both_hold", {15'd0, M_cnd}, 16'h0001);
    drive(4'd7, 4'd0, 3'b000, 0, 0, 0, 0, 1);
    chk("bubble", {15'd0, M_cnd}, 16'h0000);

    // Illegal ifun
    drive(4'd7, 4'd9, 3'b000, 0, 0, 0, 0, 0);
    drive(4'd2, 4'd15, 3'b000, 0, 0, 0, 0, 0);
    drive(4'd6, 4'd9, 3'b000, 0, 0, 0, 0, 0);

    // Randomized traffic with an asynchronous reset mid-stream
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ic;
      case ($urandom_range(0, 3))
        0: ic = 4'd7;
        1: ic = 4'd2;
        2: ic = 4'd6;
        default: ic = 4'($urandom);
      endcase
      if (i == 1500) do_reset();
      drive(ic, 4'($urandom), 3'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

`ifdef CC_TRACE_EN
    // Counter wrap: 65537 enabled writes from reset land on 1; suppressed writes don't count
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      drive(4'd6, 4'd0, 3'($urandom), 1, 0, 0, 0, 0);
    end
    chk("cnt_wrap", cc_update_cnt, 16'd1);
    drive(4'd6, 4'd0, 3'b111, 1, 0, 1, 0, 0);
    drive(4'd6, 4'd0, 3'b111, 1, 1, 0, 0, 0);
    drive(4'd6, 4'd0, 3'b111, 1, 0, 0, 1, 0);
    chk("cnt_suppress", cc_update_cnt, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_unit.md
# cc_unit

Condition-code unit for the pipelined Y86-64 core; it consumes the `{OF,SF,ZF}` flag triple produced by the 64-bit adder/ALU in Execute. It holds the architectural CC register and updates it only for committed-eligible OPq instructions. It evaluates the jXX/cmovXX condition for the instruction in Execute and pipelines the result into the Memory stage with stall/bubble control.

## Interface
Parameters:
- `CC_RESET`, `3'b001`: CC register value after reset, bit order `{OF,SF,ZF}` (ZF=1).

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `e_icode`  in  4  icode of instruction in Execute
- `e_ifun`  in  4  ifun of instruction in Execute
- `alu_cf`  in  3  ALU flags `{OF,SF,ZF}` (bit0 ZF, bit1 SF, bit2 OF), same ordering as adder output
- `set_cc`  in  1  Execute instruction is OPq and may write CC
- `m_exc`  in  1  Memory-stage status not AOK
- `w_exc`  in  1  Writeback-stage status not AOK
- `m_stall`  in  1  hold M pipeline register
- `m_bubble`  in  1  load NOP into M pipeline register
- `cc_q`  out  3  current CC register
- `e_cnd`  out  1  condition result for Execute instruction (combinational)
- `e_cnd_illegal`  out  1  `e_ifun` > 6 on a jXX/cmovXX
- `M_cnd`  out  1  registered condition for Memory stage
- `cc_update_cnt`  out  16  CC write counter (only with `CC_TRACE_EN`)

## Operation
- CC write enable: `set_cc & ~m_exc & ~w_exc & ~m_stall`. An enabled write loads `alu_cf` into `cc_q`; otherwise `cc_q` holds.
- Condition table, evaluated on `cc_q` and not on `alu_cf`:
  - ifun 0 always → 1
  - ifun 1 le → `(SF^OF)|ZF`
  - ifun 2 l → `SF^OF`
  - ifun 3 e → `ZF`
  - ifun 4 ne → `~ZF`
  - ifun 5 ge → `~(SF^OF)`
  - ifun 6 g → `~(SF^OF)&~ZF`
  - ifun 7–15 → 0, with `e_cnd_illegal`=1 when icode is JXX(7) or CMOVXX(2)
- `e_cnd_illegal` is 0 for all other icodes.
- `e_cnd` is driven for all icodes. Downstream logic gates it by icode.
- M register priority:
  - `m_stall`: hold `M_cnd`.
  - else `m_bubble`: load 0.
  - else: load `e_cnd`.
- Stall has priority when `m_stall` and `m_bubble` are both asserted.
- No state machine beyond the CC register and the M register; all arithmetic is 1-bit boolean.

## Timing
- Reset (async, immediate): `cc_q`=`CC_RESET`, `M_cnd`=0, `cc_update_cnt`=0. `e_cnd` and `e_cnd_illegal` follow from reset `cc_q` combinationally.
- `e_cnd` has zero latency from `cc_q`/`e_ifun`.
- A CC write at edge N is visible on `cc_q`/`e_cnd` after edge N. An OPq followed back-to-back by jXX/cmovXX therefore sees the updated flags without forwarding.
- `M_cnd` has 1-cycle latency from `e_cnd`.
- `m_exc` or `w_exc` asserted in the same cycle as `set_cc`: the write is dropped.
- Reset asserted mid-stream: all state returns to reset values asynchronously. The first edge after `rst_n` release behaves as a normal cycle.

## Configuration
- `CC_TRACE_EN` defined:
  - 16-bit `cc_update_cnt` increments on every enabled CC write.
  - Wraps 0xFFFF→0x0000.
  - Reset to 0.
- `CC_TRACE_EN` undefined: `cc_update_cnt` port and counter absent; behaviour otherwise identical.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants (`I_CMOVXX`=2, `I_OPQ`=6, `I_JXX`=7)
  - ifun condition constants (`C_YES`…`C_G`)
  - flag index constants (`CC_ZF`=0, `CC_SF`=1, `CC_OF`=2)
- One sub-module: `cond_eval`, a combinational condition decode (`cc`, `ifun` → `cnd`, `illegal`). Reused by any future branch-resolution logic.

## Test plan
- Reset: hold `rst_n`=0 → `cc_q`=3'b001, `M_cnd`=0. With `e_icode`=7, `e_ifun`=3 (je) → `e_cnd`=1.
- OPq write: `set_cc`=1, `alu_cf`=3'b010 for one cycle, then ifun 2 (l) → `e_cnd`=1. Next cycle `M_cnd`=1. ifun 5 (ge) → 0.
- Exception suppression: `set_cc`=1, `alu_cf`=3'b100, `w_exc`=1 → `cc_q` unchanged at 3'b001. Same with `m_exc`=1.
- Stall/bubble: `e_cnd`=1 with `m_stall`=1 → `M_cnd` holds its prior 0. Then `m_bubble`=1 → `M_cnd`=0. Both asserted → hold. CC write blocked while `m_stall`=1.
- Illegal: `e_icode`=7, `e_ifun`=9 → `e_cnd`=0, `e_cnd_illegal`=1. `e_icode`=6, `e_ifun`=9 → `e_cnd_illegal`=0.
- `CC_TRACE_EN`: 65 537 enabled writes → `cc_update_cnt`=1. Suppressed writes do not count.
